// File: rtl/dcache_port_arbiter_pkg.sv
// Shared identifiers and sizing helpers for the dcache port arbiter slice.
package dcache_port_arbiter_pkg;

  localparam logic ID_WB = 1'b0;
  localparam logic ID_LD = 1'b1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam int STARVE_W = 4;
  localparam logic [STARVE_W-1:0] STARVE_MAX = 4'd15;

  // Counter width able to hold 0..n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dcache_port_arbiter_sram_id_fifo.sv
// In-order FIFO of 1-bit master IDs for transactions accepted by the dcache port.
module sram_id_fifo
  import dcache_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     head,
  output logic [cnt_w(DEPTH)-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage holds no control meaning, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/dcache_port_arbiter.sv
// Arbitrates the single dcache port between the store-buffer drain (M0) and the load path (M1).
module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  input  logic        m1_req,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  input  logic        wb_full,
  input  logic        ld_hazard,
  output logic        dcache_data_req,
  output logic        dcache_data_wr,
  output logic [1:0]  dcache_data_size,
  output logic [31:0] dcache_data_addr,
  output logic [31:0] dcache_data_wdata,
  output logic [3:0]  dcache_data_wstrb,
  input  logic [31:0] dcache_data_rdata,
  input  logic        dcache_data_addr_ok,
  input  logic        dcache_data_data_ok
);

  localparam int CNT_W = cnt_w(OUTSTANDING);

  logic [CNT_W-1:0]    cnt;
  logic                lock_v;
  logic                lock_id;
  logic [STARVE_W-1:0] starve;

  logic e0, e1, can_issue;
  logic sel_id, sel_vld;
  logic req, hs, pop, head_id;

  // Selection: a pending lock pins the grant until the slave takes the address.
  always_comb begin
    e0        = m0_req;
    e1        = m1_req && !ld_hazard;
    can_issue = cnt < CNT_W'(OUTSTANDING);
    sel_id    = ID_WB;
    sel_vld   = 1'b0;
    if (lock_v) begin
      sel_id  = lock_id;
      sel_vld = (lock_id == ID_WB) ? e0 : e1;
    end else if (e0 && (!e1 || wb_full || starve == STARVE_W'(STARVE_LIMIT))) begin
      sel_id  = ID_WB;
      sel_vld = 1'b1;
    end else if (e1) begin
      sel_id  = ID_LD;
      sel_vld = 1'b1;
    end
    req = !rst && can_issue && sel_vld;
    hs  = req && dcache_data_addr_ok;
    pop = !rst && dcache_data_data_ok && (cnt != '0);
  end

  always_comb begin
    dcache_data_req   = req;
    dcache_data_wr    = (sel_id == ID_WB);
    dcache_data_size  = (sel_id == ID_WB) ? SIZE_WORD : m1_size;
    dcache_data_addr  = (sel_id == ID_WB) ? m0_addr : m1_addr;
    dcache_data_wdata = (sel_id == ID_WB) ? m0_wdata : 32'd0;
    dcache_data_wstrb = (sel_id == ID_WB) ? m0_wstrb : 4'd0;
    m0_addr_ok        = hs && (sel_id == ID_WB);
    m1_addr_ok        = hs && (sel_id == ID_LD);
    m0_data_ok        = pop && (head_id == ID_WB);
    m1_data_ok        = pop && (head_id == ID_LD);
    m1_rdata          = dcache_data_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_v  <= 1'b0;
      lock_id <= ID_WB;
      starve  <= '0;
    end else begin
      if (hs) begin
        lock_v <= 1'b0;
      end else if (req) begin
        lock_v  <= 1'b1;
        lock_id <= sel_id;
      end
      // Loads only count against the store drain while a store is actually waiting.
      if (!m0_req || (hs && sel_id == ID_WB)) begin
        starve <= '0;
      end else if (hs && sel_id == ID_LD && starve != STARVE_MAX) begin
        starve <= starve + 1'b1;
      end
    end
  end

  sram_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_idq (
    .clk    (clk),
    .rst    (rst),
    .push   (hs),
    .push_id(sel_id),
    .pop    (pop),
    .head   (head_id),
    .count  (cnt)
  );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed and randomized checks of dcache_port_arbiter against a queue-based reference model.
module tb_dcache_port_arbiter;

  localparam int OUT = 2;
  localparam int LIM = 4;

  logic        clk;
  logic        rst;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic [3:0]  m0_wstrb;
  logic        m0_addr_ok;
  logic        m0_data_ok;
  logic        m1_req;
  logic [1:0]  m1_size;
  logic [31:0] m1_addr;
  logic [31:0] m1_rdata;
  logic        m1_addr_ok;
  logic        m1_data_ok;
  logic        wb_full;
  logic        ld_hazard;
  logic        dcache_data_req;
  logic        dcache_data_wr;
  logic [1:0]  dcache_data_size;
  logic [31:0] dcache_data_addr;
  logic [31:0] dcache_data_wdata;
  logic [3:0]  dcache_data_wstrb;
  logic [31:0] dcache_data_rdata;
  logic        dcache_data_addr_ok;
  logic        dcache_data_data_ok;

  int checks;
  int failures;

  // Reference model state: issued-but-incomplete owners, starvation run, held grant.
  int mq[$];
  int m_starve;
  int m_lock;
  bit x_req, x_aok0, x_aok1, x_pop, x_dok0, x_dok1;
  int x_win;

  dcache_port_arbiter #(
    .OUTSTANDING (OUT),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .m0_req             (m0_req),
    .m0_addr            (m0_addr),
    .m0_wdata           (m0_wdata),
    .m0_wstrb           (m0_wstrb),
    .m0_addr_ok         (m0_addr_ok),
    .m0_data_ok         (m0_data_ok),
    .m1_req             (m1_req),
    .m1_size            (m1_size),
    .m1_addr            (m1_addr),
    .m1_rdata           (m1_rdata),
    .m1_addr_ok         (m1_addr_ok),
    .m1_data_ok         (m1_data_ok),
    .wb_full            (wb_full),
    .ld_hazard          (ld_hazard),
    .dcache_data_req    (dcache_data_req),
    .dcache_data_wr     (dcache_data_wr),
    .dcache_data_size   (dcache_data_size),
    .dcache_data_addr   (dcache_data_addr),
    .dcache_data_wdata  (dcache_data_wdata),
    .dcache_data_wstrb  (dcache_data_wstrb),
    .dcache_data_rdata  (dcache_data_rdata),
    .dcache_data_addr_ok(dcache_data_addr_ok),
    .dcache_data_data_ok(dcache_data_data_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_size = 0; m1_addr = 0;
    wb_full = 0; ld_hazard = 0;
    dcache_data_rdata = 0; dcache_data_addr_ok = 0; dcache_data_data_ok = 0;
  endtask

  task automatic model_reset();
    mq.delete();
    m_starve = 0;
    m_lock = -1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
    model_reset();
  endtask

  function automatic void model_eval();
    bit e0, e1, wv;
    e0 = m0_req;
    e1 = m1_req && !ld_hazard;
    wv = 0;
    x_win = 0;
    if (m_lock >= 0) begin
      x_win = m_lock;
      wv = (m_lock == 0) ? e0 : e1;
    end else if (e0 && (!e1 || wb_full || m_starve == LIM)) begin
      x_win = 0; wv = 1;
    end else if (e1) begin
      x_win = 1; wv = 1;
    end
    x_req  = !rst && wv && (mq.size() < OUT);
    x_aok0 = x_req && dcache_data_addr_ok && (x_win == 0);
    x_aok1 = x_req && dcache_data_addr_ok && (x_win == 1);
    x_pop  = !rst && dcache_data_data_ok && (mq.size() > 0);
    x_dok0 = 0;
    x_dok1 = 0;
    if (x_pop) begin
      x_dok0 = (mq[0] == 0);
      x_dok1 = (mq[0] == 1);
    end
  endfunction

  task automatic model_commit();
    bit hs;
    if (rst) begin
      model_reset();
    end else begin
      hs = x_aok0 || x_aok1;
      if (x_pop) void'(mq.pop_front());
      if (hs) mq.push_back(x_win);
      if (!m0_req || x_aok0) m_starve = 0;
      else if (x_aok1 && m_starve < 15) m_starve = m_starve + 1;
      if (hs) m_lock = -1;
      else if (x_req) m_lock = x_win;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    idle();
    m0_req = 1; m1_req = 1; dcache_data_addr_ok = 1; dcache_data_data_ok = 1;
    tick();
    tick();
    #1;
    checks++;
    if ({dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 00000",
               {dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
    end
    tick();
    rst = 0;
    m0_req = 0; m1_req = 0; dcache_data_addr_ok = 0;
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok} !== 2'b00) begin
      failures++;
      $display("FAIL reset_empty_dataok: got %b expected 00", {m0_data_ok, m1_data_ok});
    end
    tick();
    idle();
    model_reset();
  endtask

  task automatic test_single_load();
    do_reset();
    m1_req = 1; m1_addr = 32'h1000; m1_size = 2'd2; dcache_data_addr_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, dcache_data_addr} !==
        {4'b1001, 32'h1000}) begin
      failures++;
      $display("FAIL load_issue: got req/wr/aok0/aok1=%b addr=%h expected 1001 addr=00001000",
               {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok}, dcache_data_addr);
    end
    tick();
    m1_req = 0; dcache_data_addr_ok = 0; dcache_data_data_ok = 1;
    dcache_data_rdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok, m1_rdata} !== {2'b01, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL load_complete: got dok0/dok1=%b rdata=%h expected 01 rdata=deadbeef",
               {m0_data_ok, m1_data_ok}, m1_rdata);
    end
    tick();
    idle();
  endtask

  task automatic test_starvation();
    bit ew, ed;
    do_reset();
    m0_req = 1; m0_addr = 32'hA0; m0_wdata = 32'h11; m0_wstrb = 4'hF;
    m1_req = 1; m1_addr = 32'hB0;
    dcache_data_addr_ok = 1; dcache_data_data_ok = 1;
    for (int k = 1; k <= 12; k++) begin
      ew = (k % 5 == 0);
      ed = (k > 1) && ((k - 1) % 5 == 0);
      #1;
      checks++;
      if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !==
          {1'b1, ew, ew, !ew, ed, (k > 1) && !ed}) begin
        failures++;
        $display("FAIL starve_grant%0d: got req/wr/aok0/aok1/dok0/dok1=%b expected %b", k,
                 {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok},
                 {1'b1, ew, ew, !ew, ed, (k > 1) && !ed});
      end
      tick();
    end
    idle();
  endtask

  task automatic test_lock();
    do_reset();
    m1_req = 1; m1_addr = 32'h2000; m1_size = 2'd1;
    m0_req = 1; m0_addr = 32'h3000; m0_wdata = 32'h55; m0_wstrb = 4'hF;
    for (int c = 0; c < 3; c++) begin
      wb_full = (c >= 1);
      #1;
      checks++;
      if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, dcache_data_addr} !==
          {4'b1000, 32'h2000}) begin
        failures++;
        $display("FAIL lock_hold%0d: got req/wr/aok0/aok1=%b addr=%h expected 1000 addr=00002000",
                 c, {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok}, dcache_data_addr);
      end
      tick();
    end
    dcache_data_addr_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, dcache_data_addr} !==
        {4'b1001, 32'h2000}) begin
      failures++;
      $display("FAIL lock_accept: got req/wr/aok0/aok1=%b addr=%h expected 1001 addr=00002000",
               {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok}, dcache_data_addr);
    end
    tick();
    #1;
    checks++;
    if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok, dcache_data_addr,
         dcache_data_wdata, dcache_data_wstrb, dcache_data_size} !==
        {4'b1110, 32'h3000, 32'h55, 4'hF, 2'd2}) begin
      failures++;
      $display("FAIL lock_next_m0: got req/wr/aok0/aok1=%b addr=%h wdata=%h wstrb=%h size=%0d expected 1110 00003000 00000055 f 2",
               {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok}, dcache_data_addr,
               dcache_data_wdata, dcache_data_wstrb, dcache_data_size);
    end
    tick();
    idle();
  endtask

  task automatic test_outstanding();
    do_reset();
    m0_req = 1; m0_addr = 32'h40; dcache_data_addr_ok = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({dcache_data_req, m0_addr_ok} !== 2'b11) begin
        failures++;
        $display("FAIL outst_issue%0d: got req/aok0=%b expected 11", c, {dcache_data_req, m0_addr_ok});
      end
      tick();
    end
    #1;
    checks++;
    if ({dcache_data_req, m0_addr_ok} !== 2'b00) begin
      failures++;
      $display("FAIL outst_full: got req/aok0=%b expected 00", {dcache_data_req, m0_addr_ok});
    end
    tick();
    dcache_data_data_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, m0_data_ok, m1_data_ok} !== 3'b010) begin
      failures++;
      $display("FAIL outst_drain: got req/dok0/dok1=%b expected 010",
               {dcache_data_req, m0_data_ok, m1_data_ok});
    end
    tick();
    dcache_data_data_ok = 0;
    #1;
    checks++;
    if ({dcache_data_req, m0_addr_ok} !== 2'b11) begin
      failures++;
      $display("FAIL outst_reissue: got req/aok0=%b expected 11", {dcache_data_req, m0_addr_ok});
    end
    tick();
    idle();
  endtask

  task automatic test_mixed_order();
    do_reset();
    m0_req = 1; m0_addr = 32'h80; dcache_data_addr_ok = 1;
    tick();
    m0_req = 0; m1_req = 1; m1_addr = 32'h90;
    #1;
    checks++;
    if ({dcache_data_req, dcache_data_wr, m1_addr_ok} !== 3'b101) begin
      failures++;
      $display("FAIL mixed_issue_ld: got req/wr/aok1=%b expected 101",
               {dcache_data_req, dcache_data_wr, m1_addr_ok});
    end
    tick();
    m1_req = 0; dcache_data_addr_ok = 0; dcache_data_data_ok = 1;
    dcache_data_rdata = 32'h12345678;
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok} !== 2'b10) begin
      failures++;
      $display("FAIL mixed_first: got dok0/dok1=%b expected 10", {m0_data_ok, m1_data_ok});
    end
    tick();
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok, m1_rdata} !== {2'b01, 32'h12345678}) begin
      failures++;
      $display("FAIL mixed_second: got dok0/dok1=%b rdata=%h expected 01 12345678",
               {m0_data_ok, m1_data_ok}, m1_rdata);
    end
    tick();
    dcache_data_data_ok = 0;
    m0_req = 1; m1_req = 1; ld_hazard = 1; dcache_data_addr_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok} !== 4'b1110) begin
      failures++;
      $display("FAIL hazard_m0: got req/wr/aok0/aok1=%b expected 1110",
               {dcache_data_req, dcache_data_wr, m0_addr_ok, m1_addr_ok});
    end
    tick();
    m0_req = 0;
    #1;
    checks++;
    if ({dcache_data_req, m1_addr_ok} !== 2'b00) begin
      failures++;
      $display("FAIL hazard_block: got req/aok1=%b expected 00", {dcache_data_req, m1_addr_ok});
    end
    tick();
    ld_hazard = 0;
    #1;
    checks++;
    if ({dcache_data_req, m1_addr_ok} !== 2'b11) begin
      failures++;
      $display("FAIL hazard_clear: got req/aok1=%b expected 11", {dcache_data_req, m1_addr_ok});
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_req = 1; m0_addr = 32'hC0; dcache_data_addr_ok = 1;
    tick();
    tick();
    rst = 1; dcache_data_data_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok} !== 5'b0) begin
      failures++;
      $display("FAIL midrst_outputs: got %b expected 00000",
               {dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok});
    end
    tick();
    rst = 0; m0_req = 0; dcache_data_addr_ok = 0;
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok} !== 2'b00) begin
      failures++;
      $display("FAIL midrst_spurious: got dok0/dok1=%b expected 00", {m0_data_ok, m1_data_ok});
    end
    tick();
    dcache_data_data_ok = 0; m1_req = 1; m1_addr = 32'hD0; dcache_data_addr_ok = 1;
    #1;
    checks++;
    if ({dcache_data_req, m1_addr_ok} !== 2'b11) begin
      failures++;
      $display("FAIL midrst_reissue: got req/aok1=%b expected 11", {dcache_data_req, m1_addr_ok});
    end
    tick();
    m1_req = 0; dcache_data_addr_ok = 0; dcache_data_data_ok = 1;
    #1;
    checks++;
    if ({m0_data_ok, m1_data_ok} !== 2'b01) begin
      failures++;
      $display("FAIL midrst_route: got dok0/dok1=%b expected 01", {m0_data_ok, m1_data_ok});
    end
    tick();
    idle();
  endtask

  task automatic test_random();
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_wstrb;
    logic [1:0]  e_size;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst                 = ($urandom_range(59) == 0);
      m0_req              = ($urandom_range(2) != 0);
      m0_addr             = $urandom;
      m0_wdata            = $urandom;
      m0_wstrb            = 4'($urandom);
      m1_req              = ($urandom_range(2) != 0);
      m1_addr             = $urandom;
      m1_size             = 2'($urandom);
      wb_full             = ($urandom_range(4) == 0);
      ld_hazard           = ($urandom_range(3) == 0);
      dcache_data_addr_ok = ($urandom_range(2) != 0);
      dcache_data_data_ok = ($urandom_range(1) != 0);
      dcache_data_rdata   = $urandom;
      #1;
      model_eval();
      checks++;
      if ({dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, m1_rdata} !==
          {x_req, x_aok0, x_aok1, x_dok0, x_dok1, dcache_data_rdata}) begin
        failures++;
        $display("FAIL rand_hs%0d: got req/aok0/aok1/dok0/dok1=%b rdata=%h expected %b rdata=%h", n,
                 {dcache_data_req, m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, m1_rdata,
                 {x_req, x_aok0, x_aok1, x_dok0, x_dok1}, dcache_data_rdata);
      end
      if (x_req) begin
        e_addr  = (x_win == 0) ? m0_addr : m1_addr;
        e_wdata = (x_win == 0) ? m0_wdata : 32'd0;
        e_wstrb = (x_win == 0) ? m0_wstrb : 4'd0;
        e_size  = (x_win == 0) ? 2'd2 : m1_size;
        checks++;
        if ({dcache_data_wr, dcache_data_addr, dcache_data_wdata, dcache_data_wstrb, dcache_data_size} !==
            {(x_win == 0), e_addr, e_wdata, e_wstrb, e_size}) begin
          failures++;
          $display("FAIL rand_mux%0d: got wr=%b addr=%h wdata=%h wstrb=%h size=%0d expected wr=%b addr=%h wdata=%h wstrb=%h size=%0d",
                   n, dcache_data_wr, dcache_data_addr, dcache_data_wdata, dcache_data_wstrb,
                   dcache_data_size, (x_win == 0), e_addr, e_wdata, e_wstrb, e_size);
        end
      end
      model_commit();
      tick();
    end
    rst = 0;
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1;
    idle();
    model_reset();
    test_reset();
    test_single_load();
    test_starvation();
    test_lock();
    test_outstanding();
    test_mixed_order();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
